// File: rtl/wb_pkg.sv
// -----------------------------------------------------------------------------
// wb_pkg
// Shared definitions for the L1 write-back buffer:
//   - default line address / data widths and buffer depth
//   - the {valid, addr, data} entry record used by cache-side logic
//   - the drain FSM state encoding {IDLE, WRITE}
// -----------------------------------------------------------------------------
package wb_pkg;

    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 3;
    localparam int DEPTH_DEF  = 4;

    typedef struct packed {
        logic                  valid;
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] data;
    } wb_entry_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } wb_state_e;

endpackage

// File: rtl/wb_match.sv
// -----------------------------------------------------------------------------
// wb_match
// Combinational youngest-match search over the circular buffer entries.
// Ports:
//   valid_i  per-entry valid bits
//   excl_i   per-entry exclude mask (entries that may not match)
//   addr_i   per-entry line addresses
//   key_i    address being searched for
//   tail_i   tail pointer; the entry just before tail is the youngest
//   hit_o    some valid, non-excluded entry matches key_i
//   idx_o    index of the youngest matching entry (0 when no hit)
// -----------------------------------------------------------------------------
module wb_match #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 5,
    parameter int PTR_W  = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0]  valid_i,
    input  logic [DEPTH-1:0]  excl_i,
    input  logic [ADDR_W-1:0] addr_i [DEPTH],
    input  logic [ADDR_W-1:0] key_i,
    input  logic [PTR_W-1:0]  tail_i,
    output logic              hit_o,
    output logic [PTR_W-1:0]  idx_o
);

    logic [PTR_W-1:0] pos_s;

    // Scan from oldest to youngest so the youngest match is assigned last.
    always_comb begin
        hit_o = 1'b0;
        idx_o = '0;
        pos_s = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            // k = 0 is the slot right behind tail, i.e. the youngest one
            pos_s = tail_i - PTR_W'(k + 1);
            if (valid_i[pos_s] && !excl_i[pos_s] && (addr_i[pos_s] == key_i)) begin
                hit_o = 1'b1;
                idx_o = pos_s;
            end else begin
                hit_o = hit_o;
                idx_o = idx_o;
            end
        end
    end

endmodule

// File: rtl/wb_buffer.sv
// -----------------------------------------------------------------------------
// wb_buffer
// Write-back buffer between the L1 data cache and single-port main memory.
// Dirty evicted lines are queued in a circular FIFO (coalescing repeated
// addresses) and drained to memory whenever the cache is not using the port.
// Miss fills look up the queue combinationally so pending data is forwarded.
// Ports:
//   clock, reset                 system clock, synchronous active-high reset
//   evict_valid/ready/addr/data  eviction handshake from the cache
//   lookup_addr/hit/data         miss-fill forwarding lookup
//   mem_rd_req                   cache owns the memory port this cycle
//   mem_addr/data/wren           registered write port to main memory
//   count                        occupied entries
//   drained                      empty and no write in progress
// -----------------------------------------------------------------------------
module wb_buffer
    import wb_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       evict_valid,
    output logic                       evict_ready,
    input  logic [ADDR_W-1:0]          evict_addr,
    input  logic [DATA_W-1:0]          evict_data,
    input  logic [ADDR_W-1:0]          lookup_addr,
    output logic                       lookup_hit,
    output logic [DATA_W-1:0]          lookup_data,
    input  logic                       mem_rd_req,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [DATA_W-1:0]          mem_data,
    output logic                       mem_wren,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       drained
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Entry storage
    logic [DEPTH-1:0]  valid_q;
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];

    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    wb_state_e         state_q, state_d;

    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_data_q;
    logic              mem_wren_q;

    logic              accept_s;
    logic              coalesce_s;
    logic              alloc_s;
    logic              pop_s;
    logic [DEPTH-1:0]  excl_s;
    logic              co_hit_s;
    logic [PTR_W-1:0]  co_idx_s;
    logic [PTR_W-1:0]  lk_idx_s;
    logic              load_s;
    logic [PTR_W-1:0]  load_idx_s;
    logic [DATA_W-1:0] load_data_s;

    // Full buffer refuses even if a pop happens this cycle.
    assign evict_ready = (count_q < CNT_W'(DEPTH));
    assign accept_s    = evict_valid & evict_ready;
    assign pop_s       = (state_q == WRITE);

    // The head being written may not absorb new data: it would be lost.
    assign excl_s = pop_s ? (DEPTH'(1) << head_q) : '0;

    wb_match #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .PTR_W(PTR_W)) u_coalesce (
        .valid_i (valid_q),
        .excl_i  (excl_s),
        .addr_i  (addr_q),
        .key_i   (evict_addr),
        .tail_i  (tail_q),
        .hit_o   (co_hit_s),
        .idx_o   (co_idx_s)
    );

    wb_match #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .PTR_W(PTR_W)) u_lookup (
        .valid_i (valid_q),
        .excl_i  ({DEPTH{1'b0}}),
        .addr_i  (addr_q),
        .key_i   (lookup_addr),
        .tail_i  (tail_q),
        .hit_o   (lookup_hit),
        .idx_o   (lk_idx_s)
    );

    assign lookup_data = lookup_hit ? data_q[lk_idx_s] : {DATA_W{1'b0}};
    assign coalesce_s  = accept_s & co_hit_s;
    assign alloc_s     = accept_s & ~co_hit_s;

    // Drain FSM next state and selection of the entry to launch.
    always_comb begin
        state_d    = state_q;
        load_s     = 1'b0;
        load_idx_s = head_q;
        case (state_q)
            IDLE: begin
                if ((count_q != '0) && !mem_rd_req) begin
                    state_d    = WRITE;
                    load_s     = 1'b1;
                    load_idx_s = head_q;
                end else begin
                    state_d    = IDLE;
                end
            end
            WRITE: begin
                // Current head pops at this edge; chain the next one if present.
                if ((count_q > CNT_W'(1)) && !mem_rd_req) begin
                    state_d    = WRITE;
                    load_s     = 1'b1;
                    load_idx_s = head_q + PTR_W'(1);
                end else begin
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // A coalesce into the entry being launched must be forwarded, otherwise
    // memory would receive the stale copy and the entry would then be popped.
    always_comb begin
        if (coalesce_s && (co_idx_s == load_idx_s)) begin
            load_data_s = evict_data;
        end else begin
            load_data_s = data_q[load_idx_s];
        end
    end

    // Pointer and occupancy next state.
    always_comb begin
        count_d = count_q + CNT_W'(alloc_s) - CNT_W'(pop_s);
        head_d  = pop_s   ? (head_q + PTR_W'(1)) : head_q;
        tail_d  = alloc_s ? (tail_q + PTR_W'(1)) : tail_q;
    end

    // Control state, pointers and memory write port registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            mem_wren_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            mem_wren_q <= load_s;
            if (load_s) begin
                mem_addr_q <= addr_q[load_idx_s];
                mem_data_q <= load_data_s;
            end else begin
                mem_addr_q <= mem_addr_q;
                mem_data_q <= mem_data_q;
            end
        end
    end

    // Entry array: allocate at tail, coalesce in place, invalidate on pop.
    // Alloc at tail never collides with the popped head (count is 1..DEPTH-1).
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            if (pop_s) begin
                valid_q[head_q] <= 1'b0;
            end
            if (alloc_s) begin
                valid_q[tail_q] <= 1'b1;
                addr_q[tail_q]  <= evict_addr;
                data_q[tail_q]  <= evict_data;
            end
            if (coalesce_s) begin
                data_q[co_idx_s] <= evict_data;
            end
        end
    end

    assign mem_addr = mem_addr_q;
    assign mem_data = mem_data_q;
    assign mem_wren = mem_wren_q;
    assign count    = count_q;
    assign drained  = (count_q == '0) && (state_q == IDLE);

endmodule

// File: tb/tb_wb_buffer.sv
// -----------------------------------------------------------------------------
// tb_wb_buffer
// Self-checking bench for wb_buffer: a directed vector table, two hand-written
// multi-cycle sequences, and randomized traffic checked against a queue model.
// -----------------------------------------------------------------------------
module tb_wb_buffer;

    localparam int DEPTH = 4;

    logic       clock;
    logic       reset;
    logic       evict_valid;
    logic       evict_ready;
    logic [4:0] evict_addr;
    logic [2:0] evict_data;
    logic [4:0] lookup_addr;
    logic       lookup_hit;
    logic [2:0] lookup_data;
    logic       mem_rd_req;
    logic [4:0] mem_addr;
    logic [2:0] mem_data;
    logic       mem_wren;
    logic [2:0] count;
    logic       drained;

    int total = 0;
    int bad   = 0;

    wb_buffer #(.DEPTH(DEPTH), .ADDR_W(5), .DATA_W(3)) dut (
        .clock       (clock),
        .reset       (reset),
        .evict_valid (evict_valid),
        .evict_ready (evict_ready),
        .evict_addr  (evict_addr),
        .evict_data  (evict_data),
        .lookup_addr (lookup_addr),
        .lookup_hit  (lookup_hit),
        .lookup_data (lookup_data),
        .mem_rd_req  (mem_rd_req),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .mem_wren    (mem_wren),
        .count       (count),
        .drained     (drained)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic ev, input logic [4:0] ea, input logic [2:0] ed,
                         input logic rd, input logic [4:0] la);
        evict_valid = ev;
        evict_addr  = ea;
        evict_data  = ed;
        mem_rd_req  = rd;
        lookup_addr = la;
    endtask

    typedef struct {
        logic       ev;
        logic [4:0] ea;
        logic [2:0] ed;
        logic       rd;
        logic [4:0] la;
        int         cnt;
        logic       rdy;
        logic       wren;
        logic [4:0] ma;
        logic [2:0] md;
        logic       hit;
        logic [2:0] ld;
    } vec_t;

    function automatic vec_t mk(logic ev, logic [4:0] ea, logic [2:0] ed, logic rd,
                                logic [4:0] la, int cnt, logic rdy, logic wren,
                                logic [4:0] ma, logic [2:0] md, logic hit, logic [2:0] ld);
        vec_t v;
        v.ev = ev; v.ea = ea; v.ed = ed; v.rd = rd; v.la = la;
        v.cnt = cnt; v.rdy = rdy; v.wren = wren; v.ma = ma; v.md = md;
        v.hit = hit; v.ld = ld;
        return v;
    endfunction

    typedef struct {
        logic [4:0] a;
        logic [2:0] d;
    } ent_t;

    vec_t vt [22];

    // reference model state
    ent_t       mq [$];
    bit         m_busy;
    logic [4:0] m_a;
    logic [2:0] m_d;
    bit         m_w;

    initial begin
        logic [2:0] wr_d [8];
        int         nw;
        int         n;
        int         found;
        int         lo;
        bit         acc;
        bit         start;
        bit         heavy;
        bit         rst_r;
        ent_t       t;
        logic       e_hit;
        logic [2:0] e_ld;

        // ---------------- reset state ----------------
        reset = 1'b1;
        drive(1'b0, 5'h00, 3'd0, 1'b0, 5'h00);
        cyc();
        cyc();
        chk("rst_count",   count, 0);
        chk("rst_ready",   evict_ready, 1);
        chk("rst_wren",    mem_wren, 0);
        chk("rst_maddr",   mem_addr, 0);
        chk("rst_mdata",   mem_data, 0);
        chk("rst_hit",     lookup_hit, 0);
        chk("rst_ldata",   lookup_data, 0);
        chk("rst_drained", drained, 1);
        reset = 1'b0;

        // ---------------- vector table ----------------
        //          ev    ea     ed   rd    la     cnt rdy  wren  ma     md   hit  ld
        vt[0]  = mk(1'b1, 5'h0A, 3'd5, 1'b0, 5'h0A, 1, 1'b1, 1'b0, 5'h00, 3'd0, 1'b1, 3'd5);
        vt[1]  = mk(1'b0, 5'h00, 3'd0, 1'b0, 5'h0A, 1, 1'b1, 1'b1, 5'h0A, 3'd5, 1'b1, 3'd5);
        vt[2]  = mk(1'b0, 5'h00, 3'd0, 1'b0, 5'h0A, 0, 1'b1, 1'b0, 5'h0A, 3'd5, 1'b0, 3'd0);
        vt[3]  = mk(1'b1, 5'h01, 3'd1, 1'b1, 5'h01, 1, 1'b1, 1'b0, 5'h0A, 3'd5, 1'b1, 3'd1);
        vt[4]  = mk(1'b1, 5'h02, 3'd2, 1'b1, 5'h01, 2, 1'b1, 1'b0, 5'h0A, 3'd5, 1'b1, 3'd1);
        vt[5]  = mk(1'b1, 5'h03, 3'd3, 1'b1, 5'h01, 3, 1'b1, 1'b0, 5'h0A, 3'd5, 1'b1, 3'd1);
        vt[6]  = mk(1'b1, 5'h04, 3'd4, 1'b1, 5'h03, 4, 1'b0, 1'b0, 5'h0A, 3'd5, 1'b1, 3'd3);
        vt[7]  = mk(1'b1, 5'h1F, 3'd7, 1'b0, 5'h1F, 4, 1'b0, 1'b1, 5'h01, 3'd1, 1'b0, 3'd0);
        vt[8]  = mk(1'b0, 5'h00, 3'd0, 1'b0, 5'h03, 3, 1'b1, 1'b1, 5'h02, 3'd2, 1'b1, 3'd3);
        vt[9]  = mk(1'b0, 5'h00, 3'd0, 1'b0, 5'h03, 2, 1'b1, 1'b1, 5'h03, 3'd3, 1'b1, 3'd3);
        vt[10] = mk(1'b0, 5'h00, 3'd0, 1'b0, 5'h03, 1, 1'b1, 1'b1, 5'h04, 3'd4, 1'b0, 3'd0);
        vt[11] = mk(1'b0, 5'h00, 3'd0, 1'b0, 5'h03, 0, 1'b1, 1'b0, 5'h04, 3'd4, 1'b0, 3'd0);
        vt[12] = mk(1'b1, 5'h05, 3'd1, 1'b1, 5'h05, 1, 1'b1, 1'b0, 5'h04, 3'd4, 1'b1, 3'd1);
        vt[13] = mk(1'b1, 5'h05, 3'd6, 1'b1, 5'h05, 1, 1'b1, 1'b0, 5'h04, 3'd4, 1'b1, 3'd6);
        vt[14] = mk(1'b0, 5'h00, 3'd0, 1'b0, 5'h05, 1, 1'b1, 1'b1, 5'h05, 3'd6, 1'b1, 3'd6);
        vt[15] = mk(1'b0, 5'h00, 3'd0, 1'b0, 5'h05, 0, 1'b1, 1'b0, 5'h05, 3'd6, 1'b0, 3'd0);
        vt[16] = mk(1'b1, 5'h10, 3'd2, 1'b1, 5'h12, 1, 1'b1, 1'b0, 5'h05, 3'd6, 1'b0, 3'd0);
        vt[17] = mk(1'b1, 5'h11, 3'd7, 1'b1, 5'h12, 2, 1'b1, 1'b0, 5'h05, 3'd6, 1'b0, 3'd0);
        vt[18] = mk(1'b0, 5'h00, 3'd0, 1'b1, 5'h11, 2, 1'b1, 1'b0, 5'h05, 3'd6, 1'b1, 3'd7);
        vt[19] = mk(1'b0, 5'h00, 3'd0, 1'b0, 5'h11, 2, 1'b1, 1'b1, 5'h10, 3'd2, 1'b1, 3'd7);
        vt[20] = mk(1'b0, 5'h00, 3'd0, 1'b0, 5'h11, 1, 1'b1, 1'b1, 5'h11, 3'd7, 1'b1, 3'd7);
        vt[21] = mk(1'b0, 5'h00, 3'd0, 1'b0, 5'h11, 0, 1'b1, 1'b0, 5'h11, 3'd7, 1'b0, 3'd0);

        for (int i = 0; i < 22; i++) begin
            drive(vt[i].ev, vt[i].ea, vt[i].ed, vt[i].rd, vt[i].la);
            cyc();
            chk($sformatf("vec%0d_count", i), count, vt[i].cnt);
            chk($sformatf("vec%0d_ready", i), evict_ready, vt[i].rdy);
            chk($sformatf("vec%0d_wren", i), mem_wren, vt[i].wren);
            chk($sformatf("vec%0d_maddr", i), mem_addr, vt[i].ma);
            chk($sformatf("vec%0d_mdata", i), mem_data, vt[i].md);
            chk($sformatf("vec%0d_hit", i), lookup_hit, vt[i].hit);
            chk($sformatf("vec%0d_ldata", i), lookup_data, vt[i].ld);
            chk($sformatf("vec%0d_drained", i), drained,
                ((vt[i].cnt == 0) && !vt[i].wren) ? 1 : 0);
        end

        // ------- same address pushed while its write is in flight -------
        nw = 0;
        drive(1'b1, 5'h07, 3'd2, 1'b0, 5'h07);
        cyc();
        drive(1'b0, 5'h00, 3'd0, 1'b0, 5'h07);
        cyc();
        chk("inflight_issue_wren", mem_wren, 1);
        if (mem_wren) begin wr_d[nw] = mem_data; nw++; end
        drive(1'b1, 5'h07, 3'd3, 1'b0, 5'h07);
        cyc();
        chk("inflight_count", count, 1);
        chk("inflight_hit_data", lookup_data, 3);
        if (mem_wren) begin wr_d[nw] = mem_data; nw++; end
        drive(1'b0, 5'h00, 3'd0, 1'b0, 5'h07);
        for (int c = 0; c < 6; c++) begin
            cyc();
            if (mem_wren && nw < 8) begin wr_d[nw] = mem_data; nw++; end
        end
        chk("inflight_nwrites", nw, 2);
        chk("inflight_w0", wr_d[0], 2);
        chk("inflight_w1", (nw > 1) ? wr_d[1] : 3'd0, 3);
        chk("inflight_final_count", count, 0);

        // ------- reset in the middle of a drain -------
        drive(1'b1, 5'h01, 3'd1, 1'b1, 5'h01); cyc();
        drive(1'b1, 5'h02, 3'd2, 1'b1, 5'h01); cyc();
        drive(1'b1, 5'h03, 3'd3, 1'b1, 5'h01); cyc();
        drive(1'b0, 5'h00, 3'd0, 1'b0, 5'h01); cyc();
        chk("rstmid_first_addr", mem_addr, 5'h01);
        cyc();
        chk("rstmid_second_addr", mem_addr, 5'h02);
        reset = 1'b1;
        cyc();
        chk("rstmid_wren", mem_wren, 0);
        chk("rstmid_count", count, 0);
        chk("rstmid_drained", drained, 1);
        chk("rstmid_hit", lookup_hit, 0);
        reset = 1'b0;
        nw = 0;
        for (int c = 0; c < 6; c++) begin
            cyc();
            if (mem_wren) nw++;
        end
        chk("rstmid_no_writes", nw, 0);
        chk("rstmid_count_after", count, 0);

        // ------- randomized traffic against the queue model -------
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        mq.delete();
        m_busy = 1'b0;
        m_w = 1'b0;
        m_a = 5'h00;
        m_d = 3'd0;
        heavy = 1'b0;
        for (int cy = 0; cy < 3000; cy++) begin
            if ((cy % 64) == 0) heavy = ($urandom_range(0, 1) == 1);
            rst_r = ($urandom_range(0, 249) == 0);
            drive(($urandom_range(0, 9) < 6),
                  5'($urandom_range(0, 7)),
                  3'($urandom_range(0, 7)),
                  heavy ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 3) == 0),
                  5'($urandom_range(0, 8)));
            reset = rst_r;

            if (rst_r) begin
                mq.delete();
                m_busy = 1'b0;
                m_w = 1'b0;
                m_a = 5'h00;
                m_d = 3'd0;
            end else begin
                n = mq.size();
                acc = evict_valid && (n < DEPTH);
                start = !mem_rd_req && (m_busy ? (n > 1) : (n > 0));
                if (acc) begin
                    found = -1;
                    lo = m_busy ? 1 : 0;
                    for (int j = n - 1; j >= lo; j--) begin
                        if (found < 0 && mq[j].a == evict_addr) found = j;
                    end
                    if (found >= 0) begin
                        t = mq[found];
                        t.d = evict_data;
                        mq[found] = t;
                    end else begin
                        t.a = evict_addr;
                        t.d = evict_data;
                        mq.push_back(t);
                    end
                end
                if (start) begin
                    t = m_busy ? mq[1] : mq[0];
                    m_a = t.a;
                    m_d = t.d;
                end
                if (m_busy) void'(mq.pop_front());
                m_busy = start;
                m_w = start;
            end

            cyc();
            reset = 1'b0;

            e_hit = 1'b0;
            e_ld = 3'd0;
            for (int j = mq.size() - 1; j >= 0; j--) begin
                if (!e_hit && mq[j].a == lookup_addr) begin
                    e_hit = 1'b1;
                    e_ld = mq[j].d;
                end
            end
            chk($sformatf("rnd%0d_count", cy), count, mq.size());
            chk($sformatf("rnd%0d_ready", cy), evict_ready, (mq.size() < DEPTH) ? 1 : 0);
            chk($sformatf("rnd%0d_wren", cy), mem_wren, m_w);
            chk($sformatf("rnd%0d_maddr", cy), mem_addr, m_a);
            chk($sformatf("rnd%0d_mdata", cy), mem_data, m_d);
            chk($sformatf("rnd%0d_hit", cy), lookup_hit, e_hit);
            chk($sformatf("rnd%0d_ldata", cy), lookup_data, e_ld);
            chk($sformatf("rnd%0d_drained", cy), drained,
                ((mq.size() == 0) && !m_busy) ? 1 : 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_buffer.md
# wb_buffer

Write-back buffer between the two-way L1 data cache and the single-port main memory (`ramlpm`). It accepts dirty evicted lines (5-bit address, 3-bit data) from the cache and queues them in a small FIFO. It drains them to main memory whenever the cache is not using the memory port for a miss fill. Cache miss fills look up the buffer first, so a line still waiting in the queue is forwarded instead of stale memory data.

## Interface
- DEPTH, 4, number of buffer entries (power of two, ≥2)
- ADDR_W, 5, line address width
- DATA_W, 3, data width
- clock  in  1  single system clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- evict_valid  in  1  cache presents an evicted dirty line
- evict_ready  out  1  buffer can accept; the line transfers on a cycle with valid & ready
- evict_addr  in  ADDR_W  evicted line address
- evict_data  in  DATA_W  evicted line data
- lookup_addr  in  ADDR_W  miss-fill address from the cache
- lookup_hit  out  1  combinational: a valid entry matches lookup_addr
- lookup_data  out  DATA_W  data of the youngest matching entry; 0 when no hit
- mem_rd_req  in  1  cache owns the memory port this cycle; drain must not start
- mem_addr  out  ADDR_W  registered write address to `ramlpm`
- mem_data  out  DATA_W  registered write data
- mem_wren  out  1  registered write enable
- count  out  $clog2(DEPTH)+1  occupied entries
- drained  out  1  count==0 and FSM in IDLE

## Operation
- Storage: circular FIFO with DEPTH entries of {valid, addr, data}, a head pointer, a tail pointer and count.
- evict_ready = (count < DEPTH). This is conservative: ready stays low when full, even if a pop happens in the same cycle.
- Coalescing on accept: if evict_addr matches a valid entry that is not in flight, that entry's data is overwritten in place and count is unchanged. Otherwise the line is written at tail, tail advances and count increments.
  - "In flight" means the head entry while the FSM is in WRITE.
  - A match against the in-flight head allocates a new entry, so the newer data is not lost.
- Lookup is purely combinational over all valid entries, including the in-flight head. Among multiple matches, the youngest entry (closest to tail) wins.
- Drain FSM has two states, IDLE and WRITE.
  - IDLE → WRITE when count>0 and !mem_rd_req. At that edge, mem_addr/mem_data load from head and mem_wren goes to 1.
  - In WRITE, the head entry is popped at the next edge: head advances and count decrements.
  - WRITE → WRITE if another entry remains after the pop and !mem_rd_req. The next head loads and mem_wren stays 1.
  - WRITE → IDLE otherwise; mem_wren goes to 0.
- mem_rd_req only blocks starting a new write. A write already issued (mem_wren high this cycle) completes.
- Simultaneous accept and pop: count is unchanged. A coalesce and a pop of different entries proceed independently.

## Timing
- Reset values: count=0, head=tail=0, all valid=0, state IDLE, mem_wren=0, mem_addr=0, mem_data=0, evict_ready=1, lookup_hit=0, lookup_data=0, drained=1.
- Reset in the middle of a WRITE: all queued entries are discarded, and mem_wren is 0 from the reset edge onward.
- Accept at edge N:
  - count increments at N.
  - mem_wren is high for the cycle after edge N+1, provided mem_rd_req is low in cycle N+1.
- Sustained drain throughput is 1 entry per cycle.
- lookup_hit and lookup_data reflect state after the last edge, with zero-cycle latency.

## Structure
- Package `wb_pkg` holds: ADDR_W/DATA_W defaults, the entry struct typedef {valid, addr, data}, and the FSM state enum {IDLE, WRITE}.
- One sub-module is natural: `wb_match`, a combinational youngest-match priority search over the entries. Both lookup and coalescing use it, with a per-entry exclude mask for the in-flight head.

## Test plan
- Reset, then push {addr 5'h0A, data 3'b101} with mem_rd_req=0 → count=1; mem_wren=1 one cycle later with mem_addr=0A, mem_data=5; drained=1 after.
- Hold mem_rd_req=1 and push four entries (0x01..0x04) → count=4, evict_ready=0, mem_wren stays 0. Release mem_rd_req → four consecutive mem_wren cycles in order 01,02,03,04.
- With mem_rd_req=1, push 0x05/data 1 then 0x05/data 6 → count=1; lookup_addr=0x05 gives hit=1, data=6; drained write carries data 6.
- Push 0x07/data 2; in the cycle its WRITE is issued, push 0x07/data 3 → two memory writes, data 2 then 3; count returns to 0.
- Assert reset in the middle of draining three entries → mem_wren=0 and count=0 from the reset edge; no further writes.
- With mem_rd_req=1, hold 0x10 and 0x11 in the buffer; lookup 0x12 → hit=0, data=0; lookup 0x11 → hit=1 with the stored data.
